// File: rtl/proximity_beeper.sv
// Parking-sensor buzzer and 10-LED proximity bar, driven by distance samples from the echo stage.
// Optional 4-sample running average when PROXIMITY_BEEPER_SMOOTH_EN is defined.
module proximity_beeper #(
   parameter int unsigned TONE_HALF      = 12500,
   parameter int unsigned BEEP_ON        = 5000000,
   parameter int unsigned GAP_SCALE      = 125000,
   parameter int unsigned NEAR           = 20,
   parameter int unsigned FAR            = 400,
   parameter int unsigned LED_STEP       = 40,
   parameter int unsigned TIMEOUT_CYCLES = 10000000
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic [15:0] DIST,
   input  logic        DIST_VALID,
   output logic        DIST_READY,
   output logic        GPIO,
   output logic [9:0]  leds
);
   // state    | meaning
   // IDLE     | silent, waiting for a near-enough sample
   // CONT     | continuous tone, object very close
   // BEEP_ON  | tone for BEEP_ON cycles
   // BEEP_OFF | silence for the latched distance-scaled gap
   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_CONT     = 2'd1,
      S_BEEP_ON  = 2'd2,
      S_BEEP_OFF = 2'd3
   } state_t;

   localparam logic [15:0] NEAR_D    = 16'(NEAR);
   localparam logic [15:0] FAR_D     = 16'(FAR);
   localparam logic [15:0] LED_D     = 16'(LED_STEP);
   localparam logic [31:0] TONE_LAST = 32'(TONE_HALF - 1);
   localparam logic [31:0] BEEP_LEN  = 32'(BEEP_ON);
   localparam logic [31:0] GAP_K     = 32'(GAP_SCALE);
   localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] TMO_MAX   = 32'(TIMEOUT_CYCLES);

   state_t      state;
   logic        p1, p2;
   logic [15:0] f_comb, f_q, d_q;
   logic [31:0] tone_cnt, phase_cnt, idle_cnt;
   logic        acc, tmo, upd_silent, upd_cont, tone_wrap, expire;
   logic [15:0] lq;
   logic [3:0]  lit;
   logic [9:0]  leds_new;
   logic [31:0] gap_load;

`ifdef PROXIMITY_BEEPER_SMOOTH_EN
   logic [15:0] hist [4];
   logic        hist_empty;
   logic [17:0] hsum;
   assign hsum   = 18'(hist[0]) + 18'(hist[1]) + 18'(hist[2]) + 18'(hist[3]);
   assign f_comb = 16'(hsum >> 2);
`else
   logic [15:0] samp;
   assign f_comb = samp;
`endif

   assign DIST_READY = !(p1 || p2);
   assign acc        = DIST_VALID && DIST_READY;
   assign tmo        = !acc && (idle_cnt == TMO_LAST);
   assign upd_silent = p2 && (f_q >= FAR_D);
   assign upd_cont   = p2 && (f_q < NEAR_D);
   assign tone_wrap  = (tone_cnt == TONE_LAST);
   assign expire     = (phase_cnt <= 32'd1);
   // A same-edge update already sees its own gap; otherwise the gap follows the held D.
   assign gap_load   = 32'(p2 ? f_q : d_q) * GAP_K;
   assign lq         = f_q / LED_D;

   always_comb begin
      lit = (lq >= 16'd10) ? 4'd0 : 4'(16'd10 - lq);
      for (int i = 0; i < 10; i++) leds_new[i] = (4'(i) < lit);
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state     <= S_IDLE;
         GPIO      <= 1'b0;
         leds      <= '0;
         p1        <= 1'b0;
         p2        <= 1'b0;
         f_q       <= '0;
         d_q       <= FAR_D;
         tone_cnt  <= '0;
         phase_cnt <= '0;
         idle_cnt  <= '0;
`ifdef PROXIMITY_BEEPER_SMOOTH_EN
         for (int i = 0; i < 4; i++) hist[i] <= '0;
         hist_empty <= 1'b1;
`else
         samp <= '0;
`endif
      end else begin
         p1 <= acc;
         p2 <= p1;
         if (p1) f_q <= f_comb;
         if (acc) idle_cnt <= '0;
         else if (idle_cnt != TMO_MAX) idle_cnt <= idle_cnt + 32'd1;
`ifdef PROXIMITY_BEEPER_SMOOTH_EN
         if (tmo) hist_empty <= 1'b1;
         else if (acc) begin
            if (hist_empty) begin
               for (int i = 0; i < 4; i++) hist[i] <= DIST;
               hist_empty <= 1'b0;
            end else begin
               hist[3] <= hist[2];
               hist[2] <= hist[1];
               hist[1] <= hist[0];
               hist[0] <= DIST;
            end
         end
`else
         if (acc) samp <= DIST;
`endif
         if (tmo) begin
            state     <= S_IDLE;
            GPIO      <= 1'b0;
            leds      <= '0;
            tone_cnt  <= '0;
            phase_cnt <= '0;
         end else begin
            if (p2) begin
               d_q  <= f_q;
               leds <= leds_new;
            end
            case (state)
               S_IDLE: begin
                  GPIO <= 1'b0;
                  if (upd_cont) begin
                     state    <= S_CONT;
                     tone_cnt <= '0;
                  end else if (p2 && !upd_silent) begin
                     state     <= S_BEEP_ON;
                     phase_cnt <= BEEP_LEN;
                     tone_cnt  <= '0;
                  end
               end
               S_CONT: begin
                  if (upd_silent) begin
                     state <= S_IDLE;
                     GPIO  <= 1'b0;
                  end else if (p2 && !upd_cont) begin
                     state     <= S_BEEP_ON;
                     phase_cnt <= BEEP_LEN;
                     tone_cnt  <= '0;
                     GPIO      <= 1'b0;
                  end else if (tone_wrap) begin
                     tone_cnt <= '0;
                     GPIO     <= !GPIO;
                  end else tone_cnt <= tone_cnt + 32'd1;
               end
               S_BEEP_ON: begin
                  if (upd_silent) begin
                     state <= S_IDLE;
                     GPIO  <= 1'b0;
                  end else if (upd_cont) begin
                     state    <= S_CONT;
                     tone_cnt <= '0;
                     GPIO     <= 1'b0;
                  end else if (expire) begin
                     state     <= S_BEEP_OFF;
                     phase_cnt <= gap_load;
                     GPIO      <= 1'b0;
                  end else begin
                     phase_cnt <= phase_cnt - 32'd1;
                     if (tone_wrap) begin
                        tone_cnt <= '0;
                        GPIO     <= !GPIO;
                     end else tone_cnt <= tone_cnt + 32'd1;
                  end
               end
               default: begin
                  GPIO <= 1'b0;
                  if (upd_silent) state <= S_IDLE;
                  else if (upd_cont) begin
                     state    <= S_CONT;
                     tone_cnt <= '0;
                  end else if (expire) begin
                     state     <= S_BEEP_ON;
                     phase_cnt <= BEEP_LEN;
                     tone_cnt  <= '0;
                  end else phase_cnt <= phase_cnt - 32'd1;
               end
            endcase
         end
      end
   end
endmodule

// File: doc/proximity_beeper.md
# proximity_beeper

Downstream consumer of the ultrasonic echo-timing stage. Takes each measured distance sample over a valid/ready handshake, optionally smooths it, and turns it into a parking-sensor style buzzer output and a 10-LED proximity bar. Closer objects beep faster, very close objects give a continuous tone, and far objects or a stalled sensor give silence.

## Interface
- TONE_HALF, 12500: tone half-period in CLOCK cycles (2 kHz at 50 MHz)
- BEEP_ON, 5000000: beep on-phase length in cycles
- GAP_SCALE, 125000: off-phase cycles per distance unit
- NEAR, 20: below this distance, continuous tone
- FAR, 400: at or above this distance, silent
- LED_STEP, 40: distance units per LED
- TIMEOUT_CYCLES, 10000000: cycles without an accepted sample before going silent

- CLOCK  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- DIST  in  16  distance sample, unsigned
- DIST_VALID  in  1  sample strobe from the echo stage
- DIST_READY  out  1  block can accept a sample
- GPIO  out  1  buzzer drive
- leds  out  10  proximity bar, thermometer-coded from bit 0

## Operation
- **Acceptance:** a sample is accepted on a rising edge where DIST_VALID && DIST_READY.
  - DIST_VALID while DIST_READY=0 is ignored. The sample is dropped; there is no buffering.
- **Stage 1 (cycle after accept):** register filtered value F.
  - Smoothing off: F = DIST.
  - Smoothing on: F = (sum of last 4 accepted samples) >> 2, summed in 18 bits, truncated to 16 bits.
- **Stage 2:** register D = F, compute mode, compute leds, and compute gap = D*GAP_SCALE in 32 bits.
- **Mode from D:**
  - D >= FAR: SILENT.
  - D < NEAR: CONT.
  - Otherwise: BEEP.
- **leds:** lit count = 10 − min(D/LED_STEP, 10). Bits [count−1:0] are 1, all others 0.
- **State machine:** IDLE, CONT, BEEP_ON, BEEP_OFF.
  - IDLE: GPIO=0. Stage-2 update to CONT goes to CONT. Update to BEEP goes to BEEP_ON and loads the phase counter with BEEP_ON.
  - CONT: GPIO toggles every TONE_HALF cycles. Update to BEEP goes to BEEP_ON. Update to SILENT goes to IDLE.
  - BEEP_ON: tone as in CONT. When the phase counter expires, go to BEEP_OFF and load the counter with the latched gap.
  - BEEP_OFF: GPIO=0. When the counter expires, go to BEEP_ON.
  - Stage-2 update to SILENT or CONT from either BEEP state takes effect immediately.
  - A new gap within the BEEP band only takes effect at the next BEEP_OFF entry. The current phase is not retimed.
- **Tone counter:** reset to 0 and GPIO forced 0 on every entry to CONT or BEEP_ON. The first toggle (to 1) occurs TONE_HALF cycles after entry.
- **Timeout:** the cycle counter clears on each acceptance. When it reaches TIMEOUT_CYCLES:
  - state goes to IDLE, GPIO=0, leds=0;
  - smoothing history is marked empty.
- **Acceptance and timeout in the same cycle:** acceptance wins. The counter clears and no timeout occurs.

## Timing
- Reset values: GPIO=0, leds=0, DIST_READY=1, state IDLE, D=FAR, history empty, all counters 0.
- Reset mid-tone or mid-pipeline: every output takes its reset value on the next edge. An in-flight sample is discarded.
- Accept at edge T:
  - DIST_READY is 0 for the cycles after T and T+1, and returns to 1 after edge T+2.
  - D, leds, and the state transition take effect at edge T+2. Latency is 2 cycles.
  - The earliest next acceptance is edge T+3. Sustained throughput is one sample per 3 cycles.
- Phase counters count down and expire on the edge where they reach 0. A loaded value of N gives a phase lasting N cycles.
- gap=0 is not reachable, since D >= NEAR > 0 in BEEP. If a zero is loaded anyway, BEEP_OFF lasts 1 cycle.

## Configuration
- **Macro:** `PROXIMITY_BEEPER_SMOOTH_EN`.
- **Defined:**
  - A 4-entry sample history and a running average are used.
  - The first sample accepted while the history is empty (after reset or timeout) preloads all 4 entries.
  - Later samples shift into the history, oldest out.
- **Undefined:** there is no history logic, and F = DIST.
- Latency and handshake timing are identical in both builds.

## Test plan
- **Reset:** hold RESET 3 cycles mid-tone -> GPIO=0, leds=0, DIST_READY=1 on the next edge. The state is IDLE, and no toggles occur after release until a sample arrives.
- **Continuous tone:** DIST=10 -> CONT and leds=0x3FF at T+2. GPIO first rises at T+2+12500, then toggles every 12500 cycles.
- **Beep band:** DIST=100 -> leds=0x0FF (8 lit). ON lasts 5000000 cycles, then OFF lasts 12500000 cycles, repeating. A sample of 50 sent mid-ON leaves the current ON unchanged; the next OFF lasts 6250000 cycles.
- **Far and timeout:**
  - DIST=400 -> IDLE and leds=0 at T+2.
  - Separately, DIST=100 with no further samples -> IDLE, GPIO=0, leds=0 after exactly 10000000 cycles.
- **Handshake:** assert DIST_VALID continuously with changing data -> acceptances occur only every 3rd edge. The samples in between are dropped and never affect D.
- **Smoothing build:**
  - Samples 100, then 200, 200, 200 -> D sequence 100, 125, 150, 175.
  - Without the macro, the same samples give D sequence 100, 200, 200, 200.
